// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential radix-4 divider (div_seq).
//
// Contents:
//   div_state_e   - FSM state encodings DIV_IDLE .. DIV_DONE
//   DIV_ITERS     - number of radix-4 iterations for a 32-bit quotient
//   DIV_LAST_STEP - counter value on the final iteration
//   DIV_START     - level of div_start_i that requests a divide
//   DIV_READY     - level of ready_o that marks a valid result
//   abs32()       - magnitude of a 32-bit operand, honouring signedness
// -----------------------------------------------------------------------------
package div_seq_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // Two quotient bits per iteration, 32 quotient bits in total.
  localparam int         DIV_ITERS     = 16;
  localparam logic [4:0] DIV_LAST_STEP = 5'(DIV_ITERS - 1);

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_READY = 1'b1;

  // Magnitude of an operand. An unsigned operand is already its own
  // magnitude; 0x80000000 in signed mode maps to 0x80000000, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] abs32(input logic [31:0] value,
                                        input logic        is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_seq_r4_step.sv
// -----------------------------------------------------------------------------
// div_r4_step
// One combinational radix-4 restoring-division step.
//
// The shifted candidate {rem_in, bits_in} is compared against 1x, 2x and 3x
// the divisor; the largest multiple that still fits is subtracted and its
// multiplier becomes the 2-bit quotient digit.
//
// Ports:
//   rem_in   in  34  partial remainder before this step
//   bits_in  in   2  next two dividend bits shifted in from the right
//   divisor  in  32  divisor magnitude
//   rem_out  out 34  partial remainder after this step (always < divisor)
//   digit    out  2  quotient digit produced by this step
// -----------------------------------------------------------------------------
module div_r4_step (
  input  logic [33:0] rem_in,
  input  logic [1:0]  bits_in,
  input  logic [31:0] divisor,
  output logic [33:0] rem_out,
  output logic [1:0]  digit
);

  logic [35:0] cand;
  logic [33:0] div_x1;
  logic [33:0] div_x2;
  logic [33:0] div_x3;

  // 3x a 32-bit value needs 34 bits, so every multiple is held at 34 bits.
  // The candidate is kept at full 36-bit width for the comparisons so that
  // no remainder bit is silently dropped.
  assign cand   = {rem_in, bits_in};
  assign div_x1 = {2'b00, divisor};
  assign div_x2 = {1'b0, divisor, 1'b0};
  assign div_x3 = div_x1 + div_x2;

  // Pick the largest multiple not exceeding the candidate. Because the
  // resulting remainder is below the divisor, the subtraction can be done
  // in 34 bits without losing information.
  always_comb begin
    digit   = 2'd0;
    rem_out = cand[33:0];
    if (cand >= {2'b00, div_x3}) begin
      digit   = 2'd3;
      rem_out = cand[33:0] - div_x3;
    end else if (cand >= {2'b00, div_x2}) begin
      digit   = 2'd2;
      rem_out = cand[33:0] - div_x2;
    end else if (cand >= {2'b00, div_x1}) begin
      digit   = 2'd1;
      rem_out = cand[33:0] - div_x1;
    end
  end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle divider for DIV / DIVU in the execute stage. Holds the
// pipeline with stallreq_o while it runs 16 radix-4 iterations, then
// presents {remainder, quotient} on hilo_o until the stage advances.
//
// Latency from an accepted start: 19 cycles to ready_o, 1 cycle for a
// zero divisor.
//
// Build option:
//   DIV_EARLY_EXIT_EN - when defined, an operation with |op1| < |op2| skips
//                       the iterations entirely (ready after 3 cycles).
//
// Ports:
//   cpu_clk_50M  in   1  clock, rising edge
//   cpu_rst      in   1  asynchronous active-high reset
//   div_start_i  in   1  divide requested, held high while stalled
//   signed_i     in   1  1 = DIV, 0 = DIVU (latched at start)
//   op1_i        in  32  dividend (latched at start)
//   op2_i        in  32  divisor (latched at start)
//   flush_i      in   1  kill any operation in flight
//   exe_adv_i    in   1  execute stage advances, releasing the result
//   stallreq_o   out  1  stall request to the pipeline controller
//   ready_o      out  1  hilo_o is valid
//   hilo_o       out 64  {remainder, quotient}; zero unless ready_o
//   busy_o       out  1  divider is not idle
// -----------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        div_start_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        exe_adv_i,
  output logic        stallreq_o,
  output logic        ready_o,
  output logic [63:0] hilo_o,
  output logic        busy_o
);

  div_state_e  state;
  div_state_e  state_next;

  logic [4:0]  count;
  // [65:32] running remainder, [31:0] dividend bits still to be consumed on
  // the left and quotient digits collected on the right.
  logic [65:0] part_rem;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        signed_q;
  logic [31:0] divisor_q;
  logic [63:0] result_q;

  logic        start_req;
  logic        start_accept;
  logic [31:0] abs_op1;
  logic [31:0] abs_op2;
  logic        early_exit;
  logic [33:0] step_rem;
  logic [1:0]  step_digit;
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] raw_quo;
  logic [31:0] raw_rem;
  logic [31:0] fixed_quo;
  logic [31:0] fixed_rem;

  assign start_req    = (div_start_i == DIV_START);
  // A flush in the same cycle as a start wins; nothing is latched.
  assign start_accept = start_req && !flush_i;

  assign abs_op1 = abs32(op1_q, signed_q);
  assign abs_op2 = abs32(op2_q, signed_q);

`ifdef DIV_EARLY_EXIT_EN
  // Dividend smaller than divisor: quotient is 0 and the remainder is the
  // dividend magnitude, so the iterations can be skipped.
  assign early_exit = (abs_op1 < abs_op2);
`else
  assign early_exit = 1'b0;
`endif

  div_r4_step u_step (
    .rem_in  (part_rem[65:32]),
    .bits_in (part_rem[31:30]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .digit   (step_digit)
  );

  // Sign correction: the quotient is negative when the operand signs
  // differ, the remainder always takes the sign of the dividend. The
  // -2^31 / -1 case falls out naturally as quotient 0x80000000.
  assign raw_quo   = part_rem[31:0];
  assign raw_rem   = part_rem[63:32];
  assign neg_quo   = signed_q && (op1_q[31] ^ op2_q[31]);
  assign neg_rem   = signed_q && op1_q[31];
  assign fixed_quo = neg_quo ? (~raw_quo + 32'd1) : raw_quo;
  assign fixed_rem = neg_rem ? (~raw_rem + 32'd1) : raw_rem;

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A flush overrides every other transition and drops
  // whatever was in flight.
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: begin
        if (start_accept) begin
          state_next = (op2_i == 32'd0) ? DIV_DONE : DIV_PREP;
        end
      end
      DIV_PREP: begin
        state_next = early_exit ? DIV_FIX : DIV_ITER;
      end
      DIV_ITER: begin
        if (count == DIV_LAST_STEP) begin
          state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_next = DIV_DONE;
      end
      DIV_DONE: begin
        if (exe_adv_i || !start_req) begin
          state_next = DIV_IDLE;
        end
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
    if (flush_i) begin
      state_next = DIV_IDLE;
    end
  end

  // Datapath. Operands are captured raw at start; magnitudes are taken in
  // PREP so the sign information is still available for the fix-up.
  // The result register is cleared on every accepted start, which also
  // gives the all-zero result for a zero divisor.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      count     <= 5'd0;
      part_rem  <= 66'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      signed_q  <= 1'b0;
      divisor_q <= 32'd0;
      result_q  <= 64'd0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_accept) begin
            op1_q    <= op1_i;
            op2_q    <= op2_i;
            signed_q <= signed_i;
            result_q <= 64'd0;
          end
        end
        DIV_PREP: begin
          divisor_q <= abs_op2;
          count     <= 5'd0;
          if (early_exit) begin
            part_rem <= {2'b00, abs_op1, 32'd0};
          end else begin
            part_rem <= {34'd0, abs_op1};
          end
        end
        DIV_ITER: begin
          part_rem <= {step_rem, part_rem[29:0], step_digit};
          count    <= count + 5'd1;
        end
        DIV_FIX: begin
          result_q <= {fixed_rem, fixed_quo};
        end
        default: begin
        end
      endcase
    end
  end

  // The stall is combinational so it already covers the start cycle, and
  // it drops in DONE so the pipeline can pick up the result.
  assign stallreq_o = div_start_i && !flush_i && (state != DIV_DONE);
  assign ready_o    = (state == DIV_DONE) ? DIV_READY : ~DIV_READY;
  assign hilo_o     = (state == DIV_DONE) ? result_q : 64'd0;
  assign busy_o     = (state != DIV_IDLE);

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq. Results and latencies come from a
// reference built on 64-bit integer arithmetic.
// Honours DIV_EARLY_EXIT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_div_seq;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        div_start_i;
  logic        signed_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        exe_adv_i;
  logic        stallreq_o;
  logic        ready_o;
  logic [63:0] hilo_o;
  logic        busy_o;

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  div_seq dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .div_start_i (div_start_i),
    .signed_i    (signed_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .flush_i     (flush_i),
    .exe_adv_i   (exe_adv_i),
    .stallreq_o  (stallreq_o),
    .ready_o     (ready_o),
    .hilo_o      (hilo_o),
    .busy_o      (busy_o)
  );

  initial begin
    cpu_clk_50M = 1'b0;
    forever #10 cpu_clk_50M = ~cpu_clk_50M;
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Operands widened to 64 bits so even -2^31 / -1 divides without overflow;
  // truncating division and remainder then match DIV/DIVU directly.
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint la;
    longint lb;
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) return 64'd0;
    la = sgn ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    lb = sgn ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    q  = la / lb;
    r  = la % lb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int model_latency(input logic sgn, input logic [31:0] a,
                                       input logic [31:0] b);
    longint ma;
    longint mb;
    ma = sgn ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    mb = sgn ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 3;
`endif
    return 19;
  endfunction

  // One complete divide: start, watch the stall each cycle, check latency
  // and result, then release via exe_adv_i (or via the dropped start).
  task automatic apply_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int drop_at, input bit hold, input string tag);
    logic [63:0] exp_hilo;
    int          exp_lat;
    int          seen;
    bit          stall_ok;
    exp_hilo = model_div(sgn, a, b);
    exp_lat  = model_latency(sgn, a, b);
    @(negedge cpu_clk_50M);
    div_start_i = 1'b1;
    signed_i    = sgn;
    op1_i       = a;
    op2_i       = b;
    #1;
    check({tag, " stall_in_start_cycle"}, 64'(stallreq_o), 64'd1);
    seen     = 0;
    stall_ok = 1'b1;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(negedge cpu_clk_50M);
      if (k == 1) begin
        op1_i    = $urandom;
        op2_i    = $urandom;
        signed_i = ~sgn;
      end
      if (k == drop_at) div_start_i = 1'b0;
      #1;
      if (ready_o === 1'b1) seen = k;
      else if (stallreq_o !== div_start_i || busy_o !== 1'b1 || hilo_o !== 64'd0)
        stall_ok = 1'b0;
    end
    check({tag, " stall_busy_while_running"}, 64'(stall_ok), 64'd1);
    check({tag, " latency"}, 64'(seen), 64'(exp_lat));
    check({tag, " hilo"}, hilo_o, exp_hilo);
    check({tag, " stall_low_in_done"}, 64'(stallreq_o), 64'd0);
    if (hold) begin
      @(negedge cpu_clk_50M);
      #1;
      check({tag, " done_holds"}, {ready_o, hilo_o[62:0]}, {1'b1, exp_hilo[62:0]});
    end
    if (drop_at == 0) exe_adv_i = 1'b1;
    @(negedge cpu_clk_50M);
    exe_adv_i   = 1'b0;
    div_start_i = 1'b0;
    #1;
    check({tag, " idle_after_release"}, {busy_o, ready_o, hilo_o[61:0]}, 64'd0);
  endtask

  initial begin
    logic        rnd_sgn;
    logic [31:0] rnd_a;
    logic [31:0] rnd_b;
    bit          ready_seen;

    cpu_rst     = 1'b1;
    div_start_i = 1'b0;
    signed_i    = 1'b0;
    op1_i       = 32'd0;
    op2_i       = 32'd0;
    flush_i     = 1'b0;
    exe_adv_i   = 1'b0;

    #5;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset hilo", hilo_o, 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;

    apply_op(1'b0, 32'd100, 32'd7, 0, 1'b1, "divu_100_7");
    apply_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_m7_2");
    apply_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_min_m1");
    apply_op(1'b0, 32'd5, 32'd0, 0, 1'b0, "divu_5_0");
    apply_op(1'b0, 32'd3, 32'd10, 0, 1'b0, "divu_3_10");
    apply_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "div_7_m2");
    apply_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "divu_max_1");
    apply_op(1'b0, 32'd200, 32'd9, 4, 1'b0, "divu_start_drop");

    // Flush and start in the same idle cycle: nothing may start.
    @(negedge cpu_clk_50M);
    div_start_i = 1'b1;
    flush_i     = 1'b1;
    op1_i       = 32'd100;
    op2_i       = 32'd7;
    #1;
    check("flush_with_start stall", 64'(stallreq_o), 64'd0);
    @(negedge cpu_clk_50M);
    flush_i     = 1'b0;
    div_start_i = 1'b0;
    #1;
    check("flush_with_start busy", 64'(busy_o), 64'd0);

    // Flush during the iterations, then a fresh 9/3 two cycles later.
    @(negedge cpu_clk_50M);
    div_start_i = 1'b1;
    signed_i    = 1'b0;
    op1_i       = 32'd100;
    op2_i       = 32'd7;
    ready_seen  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge cpu_clk_50M);
      #1;
      if (ready_o !== 1'b0) ready_seen = 1'b1;
    end
    flush_i = 1'b1;
    #1;
    check("flush_mid stall", 64'(stallreq_o), 64'd0);
    @(negedge cpu_clk_50M);
    flush_i     = 1'b0;
    div_start_i = 1'b0;
    #1;
    if (ready_o !== 1'b0) ready_seen = 1'b1;
    check("flush_mid idle", {busy_o, hilo_o[62:0]}, 64'd0);
    check("flush_mid no_ready", 64'(ready_seen), 64'd0);
    apply_op(1'b0, 32'd9, 32'd3, 0, 1'b0, "divu_9_3_after_flush");

    // Reset in the middle of an iteration abandons the operation.
    @(negedge cpu_clk_50M);
    div_start_i = 1'b1;
    signed_i    = 1'b0;
    op1_i       = 32'd1000;
    op2_i       = 32'd3;
    repeat (10) @(negedge cpu_clk_50M);
    cpu_rst = 1'b1;
    #1;
    check("reset_mid outputs", {busy_o, ready_o, hilo_o[61:0]}, 64'd0);
    check("reset_mid stall", 64'(stallreq_o), 64'd1);
    @(negedge cpu_clk_50M);
    cpu_rst     = 1'b0;
    div_start_i = 1'b0;
    #1;
    check("reset_mid released", {busy_o, ready_o, hilo_o[61:0]}, 64'd0);
    apply_op(1'b0, 32'd8, 32'd2, 0, 1'b0, "divu_8_2_after_reset");

    // Random operands, both signednesses, with some small and negative divisors.
    for (int i = 0; i < 12; i++) begin
      rnd_sgn = 1'($urandom_range(0, 1));
      rnd_a   = $urandom;
      rnd_b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (rnd_sgn && $urandom_range(0, 1) == 1) rnd_b = ~rnd_b + 32'd1;
      if ($urandom_range(0, 3) == 0) rnd_a = rnd_a >> $urandom_range(1, 31);
      if (rnd_b == 32'd0) rnd_b = 32'd1;
      apply_op(rnd_sgn, rnd_a, rnd_b, 0, 1'b0, $sformatf("random_%0d", i));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: cpu_clk_50M  in  1  sole clock, rising edge.
REQ-003 Port: cpu_rst  in  1  asynchronous, active-high reset.
REQ-004 Port: div_start_i  in  1  DIV/DIVU in exe; held high for the whole stall.
REQ-005 Port: signed_i  in  1  1 = DIV, 0 = DIVU; sampled when a start is accepted.
REQ-006 Port: op1_i  in  32  dividend; sampled when a start is accepted.
REQ-007 Port: op2_i  in  32  divisor; sampled when a start is accepted.
REQ-008 Port: flush_i  in  1  exception/flush; kills the operation in flight.
REQ-009 Port: exe_adv_i  in  1  exe stage advances this cycle; frees the held result.
REQ-010 Port: stallreq_o  out  1  stall request to the pipeline controller.
REQ-011 Port: ready_o  out  1  result valid.
REQ-012 Port: hilo_o  out  64  {remainder, quotient}, with remainder in HI.
REQ-013 Port: busy_o  out  1  state is not IDLE.

Function
REQ-014 State set: IDLE, PREP, ITER, FIX, DONE.
REQ-015 IDLE: start is accepted when div_start_i=1 and flush_i=0; inputs are latched. Next state is PREP, or DONE if op2_i=0.
REQ-016 PREP: takes the absolute values when signed_i=1, clears the 66-bit partial remainder and sets the 5-bit counter to 0; next state is ITER.
REQ-017 ITER: one radix-4 step per cycle, 16 steps (2 quotient bits each); at count 15 the next state is FIX.
REQ-018 FIX (signed only): negate the quotient if op1[31]^op2[31]; negate the remainder if op1[31]; next state is DONE.
REQ-019 DONE: ready_o=1 and hilo_o holds the result. Next state is IDLE when exe_adv_i=1 or div_start_i=0; otherwise the state holds.
REQ-020 Latency: start sampled at edge T gives DONE at T+19, so ready_o=1 during cycle T+19.
REQ-021 Divide by zero: DONE at T+1 with hilo_o=64'h0.
REQ-022 stallreq_o = div_start_i & ~flush_i & (state != DONE); this is combinational, so it is high in the start cycle itself.
REQ-023 flush_i=1 in any state: next state is IDLE, ready_o=0 next cycle, result discarded.
REQ-024 Simultaneous flush_i and start in IDLE: the flush wins and no start is accepted.
REQ-025 div_start_i falling mid-operation without a flush: the operation continues to DONE, then goes to IDLE one cycle later.
REQ-026 Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no exception raised.
REQ-027 ready_o=0 and hilo_o=0 in every state except DONE.

Reset
REQ-028 cpu_rst=1 forces, asynchronously: state=IDLE, counter=0, partial remainder=0, hilo_o=0, ready_o=0, busy_o=0.
REQ-029 stallreq_o follows REQ-022 during reset. A reset asserted mid-ITER abandons the operation, and no stale result appears after release.

Configuration
REQ-030 Macro DIV_EARLY_EXIT_EN.
REQ-031 With DIV_EARLY_EXIT_EN defined: in PREP, if |op1| < |op2| the block skips ITER, sets quotient=0 and remainder=|op1|, and goes to FIX. DONE is then at T+3.
REQ-032 Without DIV_EARLY_EXIT_EN: every nonzero-divisor operation takes the full 16 ITER cycles.

Structure
REQ-033 Shared defines.v SHALL hold the state encodings (DIV_IDLE .. DIV_DONE), DIV_ITERS=16, and the existing DIV_START/DIV_READY constants.
REQ-034 Sub-module div_r4_step SHALL be combinational. It compares against 1x, 2x and 3x the divisor, selects the largest non-negative difference, and outputs the new remainder plus a 2-bit quotient digit.

Verification
REQ-035 Unsigned 100/7, start at T: stallreq_o high T..T+18; at T+19 ready_o=1 and hilo_o={32'd2, 32'd14}; exe_adv_i=1 gives IDLE at T+20.
REQ-036 Signed -7/2: hilo_o={32'hFFFFFFFF, 32'hFFFFFFFD} at T+19. Signed 0x80000000/0xFFFFFFFF: hilo_o={0, 32'h80000000}.
REQ-037 Divide by zero, 5/0: ready_o=1 at T+1 with hilo_o=0; stallreq_o low from T+1.
REQ-038 flush_i at T+5 during ITER: IDLE at T+6, ready_o never rises; a new 9/3 start at T+7 gives {0, 3} at T+26.
REQ-039 cpu_rst pulsed at T+10 then released: busy_o=0 and hilo_o=0 immediately; the next 8/2 run gives {0, 4} with the full latency.
REQ-040 With DIV_EARLY_EXIT_EN, 3/10: {3, 0} at T+3. Without it, the same operation completes at T+19.
